booth_mul_arb: RTL and testbench

Round-robin arbiter and two-stage pipeline controller that shares one 32x32 signed radix-16 Booth multiplier (`Booth_mul`, combinational) among `N_REQ` requesters. Each requester presents an operand pair over a valid/ready handshake. The block captures the winning pair into an operand register, drives the multiplier from it, and registers the 64-bit product with the requester ID on a single response channel with back-pressure. It is the only path by which client logic reaches the shared multiplier.

---
 rtl/booth_mul_arb_if.sv | 13 +
 rtl/booth_mul_arb.sv | 101 ++++++++++
 tb/tb_booth_mul_arb.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_arb_if.sv
// booth_mul_arb_if: requester and response channels of the shared multiplier arbiter
interface booth_mul_arb_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid, req_ready;
    logic [N_REQ*32-1:0] req_a, req_b;
    logic                rsp_valid, rsp_ready;
    logic [63:0]         rsp_p;
    logic [ID_W-1:0]     rsp_id;
    modport master (output req_valid, req_a, req_b, rsp_ready, input req_ready, rsp_valid, rsp_p, rsp_id);
    modport slave  (input req_valid, req_a, req_b, rsp_ready, output req_ready, rsp_valid, rsp_p, rsp_id);
endinterface

// File: rtl/booth_mul_arb.sv
// booth_mul_arb: round-robin arbiter and two-stage pipeline sharing one signed radix-16 Booth multiplier
module Booth_mul (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] p_o
);
    logic [63:0] m1, m2, m3, m4, m5, m6, m7, m8, pm;
    logic [32:0] b_ext;
    logic [4:0]  w, d;
    logic [3:0]  mag;
    assign b_ext = {b_i, 1'b0};
    assign m1 = {{32{a_i[31]}}, a_i};
    assign m2 = m1 << 1;
    assign m3 = m2 + m1;
    assign m4 = m1 << 2;
    assign m5 = m4 + m1;
    assign m6 = m3 << 1;
    assign m8 = m1 << 3;
    assign m7 = m8 - m1;
    // each 5-bit window of B recodes to a digit in -8..8; the top window carries the sign
    always_comb begin
        p_o = '0;
        w   = '0;
        d   = '0;
        mag = '0;
        pm  = '0;
        for (int k = 0; k < 8; k++) begin
            w   = b_ext[4*k +: 5];
            d   = {w[4], w[4:1]} + {4'b0, w[0]};
            mag = d[4] ? 4'(-d) : d[3:0];
            pm  = mag == 4'd1 ? m1 : mag == 4'd2 ? m2 : mag == 4'd3 ? m3 : mag == 4'd4 ? m4 :
                  mag == 4'd5 ? m5 : mag == 4'd6 ? m6 : mag == 4'd7 ? m7 : mag == 4'd8 ? m8 : '0;
            p_o = p_o + ((d[4] ? -pm : pm) << (4*k));
        end
    end
endmodule

module booth_mul_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    booth_mul_arb_if.slave  bus,
    output logic            busy
);
    logic            op_vld_q, op_vld_d, rsp_vld_q;
    logic [31:0]     op_a_q, op_b_q;
    logic [ID_W-1:0] op_id_q, rsp_id_q, rr_ptr_q, rr_ptr_d, gnt_id, idx;
    logic [63:0]     rsp_p_q, prod;
    logic            gnt_vld, adv1, adv2, hs;
    assign adv2 = !rsp_vld_q | bus.rsp_ready;
    assign adv1 = !op_vld_q | adv2;
    // reset gates acceptance so nothing is taken while the pipeline is being cleared
    assign hs       = gnt_vld & adv1 & sys_rst_n;
    assign op_vld_d = hs | (op_vld_q & !adv2);
    assign rr_ptr_d = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + ID_W'(1);
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            idx = ID_W'((int'(rr_ptr_q) + j) % N_REQ);
            gnt_vld = bus.req_valid[idx] ? 1'b1 : gnt_vld;
            gnt_id  = bus.req_valid[idx] ? idx : gnt_id;
        end
    end
    for (genvar i = 0; i < N_REQ; i++) begin : g_rdy
        assign bus.req_ready[i] = hs & (gnt_id == ID_W'(i));
    end
    Booth_mul u_mul (.a_i(op_a_q), .b_i(op_b_q), .p_o(prod));
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            op_vld_q  <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_id_q   <= '0;
            rsp_vld_q <= 1'b0;
            rsp_p_q   <= '0;
            rsp_id_q  <= '0;
            rr_ptr_q  <= '0;
        end else begin
            if (adv2) begin
                rsp_vld_q <= op_vld_q;
                rsp_p_q   <= prod;
                rsp_id_q  <= op_id_q;
            end
            op_vld_q <= op_vld_d;
            if (hs) begin
                op_a_q   <= bus.req_a[int'(gnt_id)*32 +: 32];
                op_b_q   <= bus.req_b[int'(gnt_id)*32 +: 32];
                op_id_q  <= gnt_id;
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end
    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_p     = rsp_p_q;
    assign bus.rsp_id    = rsp_id_q;
    assign busy          = op_vld_q | rsp_vld_q;
endmodule

// File: tb/tb_booth_mul_arb.sv
// tb_booth_mul_arb: directed and random scoreboard bench for booth_mul_arb
module tb_booth_mul_arb;
    localparam int N = 4;
    localparam int W = 2;
    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic busy;
    booth_mul_arb_if #(.N_REQ(N), .ID_W(W)) bus ();
    booth_mul_arb #(.N_REQ(N), .ID_W(W)) dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus), .busy(busy));
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [W-1:0] id;
        logic [63:0]  p;
    } exp_t;
    exp_t         sb[$];
    int           n_chk = 0;
    int           n_err = 0;
    logic         op_m = 1'b0;
    logic         rsp_m = 1'b0;
    logic [W-1:0] rr_m = '0;
    logic [N-1:0] acc_mask = '0;
    int           wait_n[N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mul(input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        x = longint'($signed(a));
        y = longint'($signed(b));
        return 64'(x * y);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'h7fff_ffff;
            2: return 32'h0;
            3: return 32'hffff_ffff;
            default: return $urandom;
        endcase
    endfunction

    // reference model of arbitration and pipeline occupancy, plus the scoreboard
    always @(negedge sys_clk) begin : mon
        logic [N-1:0] er;
        logic [W-1:0] g, k;
        logic         gv, a1, a2;
        if (!sys_rst_n) begin
            sb.delete();
            op_m = 1'b0;
            rsp_m = 1'b0;
            rr_m = '0;
            acc_mask = '0;
            foreach (wait_n[i]) wait_n[i] = 0;
        end else begin
            gv = 1'b0;
            g = '0;
            for (int j = N - 1; j >= 0; j--) begin
                k = W'((int'(rr_m) + j) % N);
                if (bus.req_valid[k]) begin
                    gv = 1'b1;
                    g = k;
                end
            end
            a2 = !rsp_m | bus.rsp_ready;
            a1 = !op_m | a2;
            er = (gv && a1) ? (N'(1) << g) : '0;
            check("req_ready", 64'(bus.req_ready), 64'(er));
            check("rsp_valid", 64'(bus.rsp_valid), 64'(rsp_m));
            check("busy", 64'(busy), 64'(op_m | rsp_m));
            if (rsp_m) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    check("rsp_p", bus.rsp_p, sb[0].p);
                    check("rsp_id", 64'(bus.rsp_id), 64'(sb[0].id));
                    if (bus.rsp_ready) void'(sb.pop_front());
                end
            end
            if (er != 0) begin
                for (int i = 0; i < N; i++) if (bus.req_valid[i]) wait_n[i]++;
                check("max_wait", 64'(wait_n[g] <= N), 64'(1));
                wait_n[g] = 0;
                sb.push_back('{g, mul(bus.req_a[int'(g)*32 +: 32], bus.req_b[int'(g)*32 +: 32])});
                rr_m = (int'(g) == N - 1) ? '0 : g + W'(1);
            end
            acc_mask = er;
            if (a2) rsp_m = op_m;
            op_m = (er != 0) | (op_m & !a2);
        end
    end

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        int n = 0;
        bus.req_valid[i] = 1'b1;
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
        #1 check("rdy_vec", 64'(bus.req_ready), 64'(N'(1) << i));
        do begin
            @(negedge sys_clk);
            n++;
        end while (!bus.req_ready[i] && n < 20);
        check("same_cycle_grant", 64'(n), 64'(1));
        @(posedge sys_clk);
        #1 bus.req_valid[i] = 1'b0;
        check("lat_early", 64'(bus.rsp_valid), 64'(0));
        @(posedge sys_clk);
        #1 check("lat_vld", 64'(bus.rsp_valid), 64'(1));
        check("prod", bus.rsp_p, exp);
        check("id", 64'(bus.rsp_id), 64'(i));
    endtask

    task automatic drain();
        int t = 0;
        bus.rsp_ready = 1'b1;
        while (busy && t < 50) begin
            @(posedge sys_clk);
            #1 t++;
        end
        check("drain", 64'(busy), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] mask;
        logic [63:0]  hp;
        logic [W-1:0] hi;
        int           hs_cnt, pops, t;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        #12 bus.req_valid[1] = 1'b1;
        #1 check("rst_ready", 64'(bus.req_ready), 64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rsp_p", bus.rsp_p, 64'(0));
        check("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
        bus.req_valid = '0;
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1 bus.rsp_ready = 1'b1;
        issue(0, 32'd3, 32'd7, 64'd21);
        issue(1, -32'sd5, 32'd6, 64'hFFFF_FFFF_FFFF_FFE2);
        issue(2, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        issue(3, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
        drain();
        // round-robin with all requesters held valid
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i] = 1'b1;
            bus.req_a[i*32 +: 32] = 32'(i + 1);
            bus.req_b[i*32 +: 32] = 32'd10;
        end
        @(posedge sys_clk);
        @(posedge sys_clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk);
            check("rr_vld", 64'(bus.rsp_valid), 64'(1));
            check("rr_id", 64'(bus.rsp_id), 64'(k % N));
            check("rr_p", bus.rsp_p, 64'((k % N + 1) * 10));
        end
        @(posedge sys_clk);
        #1 bus.req_valid = '0;
        drain();
        // back-pressure: stages fill, third request waits
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1110;
        bus.req_a[32 +: 32] = 32'd11;
        bus.req_b[32 +: 32] = 32'd2;
        bus.req_a[64 +: 32] = 32'd12;
        bus.req_b[64 +: 32] = 32'd3;
        bus.req_a[96 +: 32] = -32'sd4;
        bus.req_b[96 +: 32] = 32'd9;
        hs_cnt = 0;
        hp = '0;
        hi = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            mask = bus.req_ready;
            if (mask != 0) hs_cnt++;
            if (c == 2) begin
                hp = bus.rsp_p;
                hi = bus.rsp_id;
            end
            if (c > 2) begin
                check("bp_hold_p", bus.rsp_p, hp);
                check("bp_hold_id", 64'(bus.rsp_id), 64'(hi));
            end
            @(posedge sys_clk);
            #1 bus.req_valid = bus.req_valid & ~mask;
        end
        check("bp_hs", 64'(hs_cnt), 64'(2));
        check("bp_rdy", 64'(bus.req_ready), 64'(0));
        bus.rsp_ready = 1'b1;
        pops = 0;
        t = 0;
        while ((busy || bus.req_valid != 0) && t < 20) begin
            @(negedge sys_clk);
            mask = bus.req_ready;
            if (bus.rsp_valid) pops++;
            @(posedge sys_clk);
            #1 bus.req_valid = bus.req_valid & ~mask;
            t++;
        end
        check("bp_pops", 64'(pops), 64'(3));
        // reset with both stages full
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1001;
        bus.req_a[0 +: 32] = 32'd1;
        bus.req_b[0 +: 32] = 32'd1;
        bus.req_a[96 +: 32] = 32'd2;
        bus.req_b[96 +: 32] = 32'd2;
        repeat (3) @(posedge sys_clk);
        #1 check("full_before_rst", 64'(bus.rsp_valid & busy), 64'(1));
        #2 sys_rst_n = 1'b0;
        #1 check("arst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_ready", 64'(bus.req_ready), 64'(0));
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1 issue(2, 32'd5, -32'sd3, -64'sd15);
        drain();
        // random soak
        repeat (10000) begin
            @(posedge sys_clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] || acc_mask[i]) begin
                    bus.req_valid[i] = $urandom_range(0, 2) != 0;
                    bus.req_a[i*32 +: 32] = pick();
                    bus.req_b[i*32 +: 32] = pick();
                end
            end
            bus.rsp_ready = $urandom_range(0, 3) != 0;
        end
        @(posedge sys_clk);
        #1 bus.req_valid = '0;
        drain();
        check("sb_empty_end", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
